instr_fetch: RTL and testbench

INSTR_FETCH -- requirements
Module: instr_fetch

---
 rtl/riscv_pkg.sv | 22 ++
 rtl/instr_fetch.sv | 124 ++++++++++++
 tb/tb_instr_fetch.sv | 308 ++++++++++++++++++++++++++++++
 3 files changed

// File: rtl/riscv_pkg.sv
// Shared RV32 constants and the fetch-stage state encoding.
// Consumed by the instruction fetch unit and anything that talks to it.
package riscv_pkg;

    localparam int unsigned XLEN = 32;

    localparam logic [XLEN-1:0] NOP_INSTR        = 32'h0000_0013;
    localparam logic [XLEN-1:0] RESET_PC_DEFAULT = 32'h0000_0000;

    typedef enum logic [2:0] {
        S_IDLE,
        S_REQ,
        S_WAIT,
        S_HOLD,
        S_DRAIN
    } fetch_state_e;

    function automatic logic [XLEN-1:0] align_word(input logic [XLEN-1:0] addr);
        return {addr[XLEN-1:2], 2'b00};
    endfunction

endpackage

// File: rtl/instr_fetch.sv
// Single-outstanding instruction fetch unit: requests one word, hands it to the
// decoder, and restarts at a redirect target, draining any in-flight response.
module instr_fetch
    import riscv_pkg::XLEN, riscv_pkg::fetch_state_e, riscv_pkg::align_word,
           riscv_pkg::S_IDLE, riscv_pkg::S_REQ, riscv_pkg::S_WAIT,
           riscv_pkg::S_HOLD, riscv_pkg::S_DRAIN;
#(
    parameter logic [XLEN-1:0] RESET_PC  = riscv_pkg::RESET_PC_DEFAULT,
    parameter logic [XLEN-1:0] NOP_INSTR = riscv_pkg::NOP_INSTR
) (
    input  logic            clk,
    input  logic            rst_n,
    output logic            imem_req,
    output logic [XLEN-1:0] imem_addr,
    input  logic            imem_gnt,
    input  logic            imem_rvalid,
    input  logic [XLEN-1:0] imem_rdata,
    input  logic            redirect_valid,
    input  logic [XLEN-1:0] redirect_pc,
    output logic            if_valid,
    output logic [XLEN-1:0] if_instr,
    output logic [XLEN-1:0] if_pc,
    input  logic            id_ready,
    output logic            misalign_err
);

    fetch_state_e    r_state;
    fetch_state_e    w_state_next;
    logic [XLEN-1:0] r_pc;
    logic [XLEN-1:0] w_pc_next;
    logic [XLEN-1:0] w_pc_incr;
    logic [XLEN-1:0] w_redirect_pc;
    logic            w_load;
    logic            w_consume;

    logic            r_imem_req;
    logic [XLEN-1:0] r_imem_addr;
    logic            r_if_valid;
    logic [XLEN-1:0] r_if_instr;
    logic [XLEN-1:0] r_if_pc;
    logic            r_misalign;

    // Plain XLEN-bit addition wraps 0xFFFF_FFFC back to zero.
    assign w_pc_incr     = r_pc + XLEN'(4);
    assign w_redirect_pc = align_word(redirect_pc);

    // NOTE: every always_comb output gets a default first, so no path can infer a latch.
    always_comb begin
        w_state_next = r_state;
        w_pc_next    = r_pc;
        w_load       = 1'b0;
        w_consume    = 1'b0;

        unique case (r_state)
            S_IDLE:  w_state_next = S_REQ;
            S_REQ:   if (imem_gnt) w_state_next = S_WAIT;
            S_WAIT: begin
                if (imem_rvalid) begin
                    w_state_next = S_HOLD;
                    w_load       = 1'b1;
                    w_pc_next    = w_pc_incr;
                end
            end
            S_HOLD: begin
                if (id_ready) begin
                    w_state_next = S_REQ;
                    w_consume    = 1'b1;
                end
            end
            S_DRAIN: if (imem_rvalid) w_state_next = S_REQ;
            default: w_state_next = S_IDLE;
        endcase

        // A redirect wins everywhere; a granted-but-unanswered request must drain first.
        if (redirect_valid) begin
            w_pc_next = w_redirect_pc;
            w_load    = 1'b0;
            w_consume = 1'b0;
            unique case (r_state)
                S_REQ:   w_state_next = imem_gnt    ? S_DRAIN : S_REQ;
                S_WAIT:  w_state_next = imem_rvalid ? S_REQ   : S_DRAIN;
                S_DRAIN: w_state_next = imem_rvalid ? S_REQ   : S_DRAIN;
                default: w_state_next = S_REQ;
            endcase
        end
    end

    // NOTE: sequential state uses non-blocking assignments so all flops update together.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state     <= S_IDLE;
            r_pc        <= align_word(RESET_PC);
            r_imem_req  <= 1'b0;
            r_imem_addr <= align_word(RESET_PC);
            r_if_valid  <= 1'b0;
            r_if_instr  <= NOP_INSTR;
            r_if_pc     <= align_word(RESET_PC);
            r_misalign  <= 1'b0;
        end else begin
            r_state     <= w_state_next;
            r_pc        <= w_pc_next;
            r_imem_req  <= (w_state_next == S_REQ);
            r_imem_addr <= w_pc_next;
            r_misalign  <= redirect_valid && (redirect_pc[1:0] != 2'b00);

            if (redirect_valid || w_consume) begin
                r_if_valid <= 1'b0;
                r_if_instr <= NOP_INSTR;
            end else if (w_load) begin
                r_if_valid <= 1'b1;
                r_if_instr <= imem_rdata;
                r_if_pc    <= r_pc;
            end
        end
    end

    assign imem_req     = r_imem_req;
    assign imem_addr    = r_imem_addr;
    assign if_valid     = r_if_valid;
    assign if_instr     = r_if_instr;
    assign if_pc        = r_if_pc;
    assign misalign_err = r_misalign;

endmodule

// File: tb/tb_instr_fetch.sv
// Directed bench for instr_fetch: a flag-based transaction model is compared on
// every cycle, and literal expectations pin the key scenarios.
module tb_instr_fetch;

    localparam logic [31:0] NOP    = 32'h0000_0013;
    localparam logic [31:0] RST_PC = 32'h0000_0000;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        imem_req;
    logic [31:0] imem_addr;
    logic        imem_gnt = 1'b0;
    logic        imem_rvalid = 1'b0;
    logic [31:0] imem_rdata = '0;
    logic        redirect_valid = 1'b0;
    logic [31:0] redirect_pc = '0;
    logic        if_valid;
    logic [31:0] if_instr;
    logic [31:0] if_pc;
    logic        id_ready = 1'b1;
    logic        misalign_err;

    always #5 clk = ~clk;

    instr_fetch dut (
        .clk            (clk),
        .rst_n          (rst_n),
        .imem_req       (imem_req),
        .imem_addr      (imem_addr),
        .imem_gnt       (imem_gnt),
        .imem_rvalid    (imem_rvalid),
        .imem_rdata     (imem_rdata),
        .redirect_valid (redirect_valid),
        .redirect_pc    (redirect_pc),
        .if_valid       (if_valid),
        .if_instr       (if_instr),
        .if_pc          (if_pc),
        .id_ready       (id_ready),
        .misalign_err   (misalign_err)
    );

    int n_checks = 0;
    int n_errors = 0;
    bit saw_dead = 1'b0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_errors++;
            $display("FAIL %s: got 0x%08h, expected 0x%08h (t=%0t)", name, act, exp, $time);
        end
    endtask

    // Transaction model: "started", "outstanding request", "response to drop",
    // "instruction held for decoder".
    bit          m_started, m_out, m_drop, m_have, m_mis;
    logic [31:0] m_pc, m_instr, m_ifpc;

    always @(posedge clk or negedge rst_n) begin : model
        bit          req_now, granted, resp, n_out, n_drop, n_have;
        logic [31:0] n_pc, n_instr, n_ifpc;
        if (!rst_n) begin
            m_started <= 1'b0;
            m_out     <= 1'b0;
            m_drop    <= 1'b0;
            m_have    <= 1'b0;
            m_mis     <= 1'b0;
            m_pc      <= RST_PC;
            m_instr   <= NOP;
            m_ifpc    <= RST_PC;
        end else begin
            req_now = m_started && !m_out && !m_have;
            granted = req_now && imem_gnt;
            resp    = m_out && imem_rvalid;
            n_pc    = m_pc;
            n_instr = m_instr;
            n_ifpc  = m_ifpc;
            n_have  = m_have;
            n_out   = (m_out && !resp) || granted;
            if (redirect_valid) begin
                n_pc   = redirect_pc & 32'hFFFF_FFFC;
                n_have = 1'b0;
                n_drop = n_out;
            end else begin
                n_drop = m_drop && n_out;
                if (resp && !m_drop) begin
                    n_have  = 1'b1;
                    n_instr = imem_rdata;
                    n_ifpc  = m_pc;
                    n_pc    = m_pc + 32'd4;
                end
                if (m_have && id_ready) n_have = 1'b0;
            end
            m_started <= 1'b1;
            m_out     <= n_out;
            m_drop    <= n_drop;
            m_have    <= n_have;
            m_pc      <= n_pc;
            m_instr   <= n_instr;
            m_ifpc    <= n_ifpc;
            m_mis     <= redirect_valid && (redirect_pc[1:0] != 2'b00);
        end
    end

    always @(negedge clk) begin
        if (rst_n) begin
            check("m_imem_req", imem_req, m_started && !m_out && !m_have);
            check("m_imem_addr", imem_addr, m_pc);
            check("m_if_valid", if_valid, m_have);
            check("m_if_instr", if_instr, m_have ? m_instr : NOP);
            check("m_misalign", misalign_err, m_mis);
            if (m_have) check("m_if_pc", if_pc, m_ifpc);
            if (if_valid && if_instr == 32'hDEADBEEF) saw_dead = 1'b1;
        end
    end

    task automatic cyc();
        @(negedge clk);
        #1;
    endtask

    initial begin : stim
        bit          pend = 1'b0;
        logic [31:0] pend_addr = '0;
        int          vcount = 0;
        logic [31:0] vpc [3] = '{32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'hFFFF_FFFF};
        logic [31:0] vins[3] = '{32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'hFFFF_FFFF};
        int          vcyc[3] = '{-100, -100, -100};

        repeat (3) cyc();
        check("rst_imem_req", imem_req, 0);
        check("rst_imem_addr", imem_addr, RST_PC);
        check("rst_if_valid", if_valid, 0);
        check("rst_if_instr", if_instr, NOP);
        check("rst_if_pc", if_pc, RST_PC);
        check("rst_misalign", misalign_err, 0);
        rst_n = 1'b1;

        // Streaming fetch: grant always, response one cycle after grant.
        for (int i = 0; i < 9; i++) begin
            cyc();
            if (if_valid) begin
                if (vcount < 3) begin
                    vpc[vcount]  = if_pc;
                    vins[vcount] = if_instr;
                    vcyc[vcount] = i;
                end
                vcount++;
            end
            imem_rvalid = pend;
            imem_rdata  = pend ? (32'h1000_0000 | pend_addr) : 32'h0;
            pend        = imem_req;
            pend_addr   = imem_addr;
            imem_gnt    = 1'b1;
        end
        imem_gnt    = 1'b0;
        imem_rvalid = 1'b0;
        check("stream_count", vcount, 3);
        check("stream_pc0", vpc[0], 32'h0);
        check("stream_pc1", vpc[1], 32'h4);
        check("stream_pc2", vpc[2], 32'h8);
        check("stream_ins0", vins[0], 32'h1000_0000);
        check("stream_ins1", vins[1], 32'h1000_0004);
        check("stream_ins2", vins[2], 32'h1000_0008);
        check("stream_gap01", vcyc[1] - vcyc[0], 3);
        check("stream_gap12", vcyc[2] - vcyc[1], 3);

        // Decoder stall with a held instruction.
        cyc();
        check("stall_req_addr", imem_addr, 32'hC);
        imem_gnt = 1'b1;
        cyc();
        imem_gnt    = 1'b0;
        imem_rvalid = 1'b1;
        imem_rdata  = 32'h0050_0093;
        id_ready    = 1'b0;
        cyc();
        imem_rvalid = 1'b0;
        for (int i = 0; i < 5; i++) begin
            cyc();
            check("stall_valid", if_valid, 1);
            check("stall_instr", if_instr, 32'h0050_0093);
            check("stall_pc", if_pc, 32'hC);
            check("stall_req", imem_req, 0);
        end
        id_ready = 1'b1;
        cyc();
        check("stall_done_req", imem_req, 1);
        check("stall_done_addr", imem_addr, 32'h10);

        // Redirect while waiting; late response must be drained.
        imem_gnt = 1'b1;
        cyc();
        imem_gnt       = 1'b0;
        redirect_valid = 1'b1;
        redirect_pc    = 32'h100;
        cyc();
        redirect_valid = 1'b0;
        check("drain_req", imem_req, 0);
        cyc();
        imem_rvalid = 1'b1;
        imem_rdata  = 32'hDEADBEEF;
        cyc();
        imem_rvalid = 1'b0;
        check("drain_done_req", imem_req, 1);
        check("drain_done_addr", imem_addr, 32'h100);
        check("drain_valid", if_valid, 0);

        // Misaligned redirect coincident with a response: no drain.
        imem_gnt = 1'b1;
        cyc();
        imem_gnt       = 1'b0;
        imem_rvalid    = 1'b1;
        imem_rdata     = 32'h1111_1111;
        redirect_valid = 1'b1;
        redirect_pc    = 32'h202;
        cyc();
        redirect_valid = 1'b0;
        imem_rvalid    = 1'b0;
        check("mis_pulse", misalign_err, 1);
        check("mis_req", imem_req, 1);
        check("mis_addr", imem_addr, 32'h200);
        check("mis_valid", if_valid, 0);
        cyc();
        check("mis_pulse_end", misalign_err, 0);
        check("mis_addr_hold", imem_addr, 32'h200);

        // PC wrap at the top of the address space.
        redirect_valid = 1'b1;
        redirect_pc    = 32'hFFFF_FFFC;
        cyc();
        redirect_valid = 1'b0;
        check("wrap_addr_top", imem_addr, 32'hFFFF_FFFC);
        imem_gnt = 1'b1;
        cyc();
        imem_gnt    = 1'b0;
        imem_rvalid = 1'b1;
        imem_rdata  = 32'h2222_2222;
        cyc();
        imem_rvalid = 1'b0;
        check("wrap_if_pc", if_pc, 32'hFFFF_FFFC);
        check("wrap_if_instr", if_instr, 32'h2222_2222);
        cyc();
        check("wrap_req", imem_req, 1);
        check("wrap_addr", imem_addr, 32'h0);

        // Redirect on the granting cycle, then response discarded.
        imem_gnt       = 1'b1;
        redirect_valid = 1'b1;
        redirect_pc    = 32'h40;
        cyc();
        imem_gnt       = 1'b0;
        redirect_valid = 1'b0;
        check("gntredir_req", imem_req, 0);
        check("gntredir_addr", imem_addr, 32'h40);
        imem_rvalid = 1'b1;
        imem_rdata  = 32'h4444_4444;
        cyc();
        imem_rvalid = 1'b0;
        check("gntredir_done_req", imem_req, 1);
        check("gntredir_valid", if_valid, 0);

        // Redirect while holding a stalled instruction.
        imem_gnt = 1'b1;
        cyc();
        imem_gnt    = 1'b0;
        imem_rvalid = 1'b1;
        imem_rdata  = 32'h5555_5555;
        id_ready    = 1'b0;
        cyc();
        imem_rvalid    = 1'b0;
        check("hold_pc", if_pc, 32'h40);
        redirect_valid = 1'b1;
        redirect_pc    = 32'h80;
        cyc();
        redirect_valid = 1'b0;
        id_ready       = 1'b1;
        check("holdredir_valid", if_valid, 0);
        check("holdredir_instr", if_instr, NOP);
        check("holdredir_addr", imem_addr, 32'h80);

        // Asynchronous reset while waiting; stray response ignored afterwards.
        imem_gnt = 1'b1;
        cyc();
        imem_gnt    = 1'b0;
        rst_n       = 1'b0;
        imem_rvalid = 1'b1;
        imem_rdata  = 32'h3333_3333;
        #1;
        check("arst_req", imem_req, 0);
        check("arst_addr", imem_addr, RST_PC);
        check("arst_valid", if_valid, 0);
        check("arst_instr", if_instr, NOP);
        cyc();
        rst_n = 1'b1;
        cyc();
        imem_rvalid = 1'b0;
        check("post_rst_req", imem_req, 1);
        check("post_rst_addr", imem_addr, RST_PC);
        check("post_rst_valid", if_valid, 0);
        repeat (2) cyc();

        check("no_deadbeef", saw_dead, 0);
        $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
        $finish;
    end

endmodule
